// File: rtl/tdm_demux4.sv
// Purpose: TDM receive demux; locks to slot-0 frame sync, collects 4 slots, publishes whole frames.
// Latency: out0..out3 and frame_valid update 1 clk after the slot-3 beat is sampled.
// Backpressure: none; a beat is taken on every din_valid cycle, and idle cycles only hold state.
module tdm_demux4 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             frame_sync,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic             frame_valid,
  output logic             s0,
  output logic             s1,
  output logic             locked,
  output logic             sync_err
);

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       slot_q, slot_d;
  logic [WIDTH-1:0] sh0_q, sh0_d;
  logic [WIDTH-1:0] sh1_q, sh1_d;
  logic [WIDTH-1:0] sh2_q, sh2_d;
  logic [WIDTH-1:0] out0_q, out0_d;
  logic [WIDTH-1:0] out1_q, out1_d;
  logic [WIDTH-1:0] out2_q, out2_d;
  logic [WIDTH-1:0] out3_q, out3_d;
  logic             frame_valid_q, frame_valid_d;
  logic             sync_err_q, sync_err_d;

  // Next-state: slot tracking, shadow capture and atomic publish of a complete frame
  always_comb begin
    state_d       = state_q;
    slot_d        = slot_q;
    sh0_d         = sh0_q;
    sh1_d         = sh1_q;
    sh2_d         = sh2_q;
    out0_d        = out0_q;
    out1_d        = out1_q;
    out2_d        = out2_q;
    out3_d        = out3_q;
    frame_valid_d = 1'b0;
    sync_err_d    = 1'b0;
    if (din_valid) begin
      if (state_q == HUNT) begin
        // Unsynced beats are dropped silently until a marker shows up
        if (frame_sync) begin
          sh0_d   = din;
          slot_d  = 2'd1;
          state_d = LOCKED;
        end
      end else if (frame_sync) begin
        // A marker anywhere but slot 0 restarts the frame; the partial one is abandoned
        if (slot_q != 2'd0) begin
          sync_err_d = 1'b1;
        end
        sh0_d  = din;
        slot_d = 2'd1;
      end else begin
        case (slot_q)
          2'd0: begin
            sync_err_d = 1'b1;
            state_d    = HUNT;
            slot_d     = 2'd0;
          end
          2'd1: begin
            sh1_d  = din;
            slot_d = 2'd2;
          end
          2'd2: begin
            sh2_d  = din;
            slot_d = 2'd3;
          end
          default: begin
            // Slot 3 completes the frame; all four outputs move together
            out0_d        = sh0_q;
            out1_d        = sh1_q;
            out2_d        = sh2_q;
            out3_d        = din;
            frame_valid_d = 1'b1;
            slot_d        = 2'd0;
          end
        endcase
      end
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= HUNT;
      slot_q        <= 2'd0;
      sh0_q         <= '0;
      sh1_q         <= '0;
      sh2_q         <= '0;
      out0_q        <= '0;
      out1_q        <= '0;
      out2_q        <= '0;
      out3_q        <= '0;
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      slot_q        <= slot_d;
      sh0_q         <= sh0_d;
      sh1_q         <= sh1_d;
      sh2_q         <= sh2_d;
      out0_q        <= out0_d;
      out1_q        <= out1_d;
      out2_q        <= out2_d;
      out3_q        <= out3_d;
      frame_valid_q <= frame_valid_d;
      sync_err_q    <= sync_err_d;
    end
  end

  assign out0        = out0_q;
  assign out1        = out1_q;
  assign out2        = out2_q;
  assign out3        = out3_q;
  assign frame_valid = frame_valid_q;
  assign sync_err    = sync_err_q;
  assign s0          = slot_q[0];
  assign s1          = slot_q[1];
  assign locked      = (state_q == LOCKED);

endmodule

// File: tb/tb_tdm_demux4.sv
// Purpose: self-checking bench for tdm_demux4 (WIDTH=8) against a queue-based frame model.
// Latency: every cycle is compared 1 time unit after the rising edge.
// Backpressure: n/a; stimulus drives din_valid idles directly.
module tb_tdm_demux4;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] din;
  logic         din_valid;
  logic         frame_sync;
  logic [W-1:0] out0, out1, out2, out3;
  logic         frame_valid, s0, s1, locked, sync_err;

  int n_checks;
  int n_fail;

  // Reference model: the partial frame is a queue; its length is the expected slot.
  logic [W-1:0] m_frame[$];
  logic [W-1:0] m_out[4];
  bit           m_locked;
  bit           m_fv;
  bit           m_err;

  tdm_demux4 #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .frame_sync(frame_sync),
    .out0(out0), .out1(out1), .out2(out2), .out3(out3), .frame_valid(frame_valid),
    .s0(s0), .s1(s1), .locked(locked), .sync_err(sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input logic rst, input logic v, input logic [W-1:0] d, input logic fs);
    m_fv  = 0;
    m_err = 0;
    if (!rst) begin
      m_locked = 0;
      m_frame.delete();
      for (int i = 0; i < 4; i++) m_out[i] = '0;
    end else if (v) begin
      if (!m_locked) begin
        if (fs) begin
          m_frame.delete();
          m_frame.push_back(d);
          m_locked = 1;
        end
      end else if (fs) begin
        if (m_frame.size() != 0) m_err = 1;
        m_frame.delete();
        m_frame.push_back(d);
      end else if (m_frame.size() == 0) begin
        m_err    = 1;
        m_locked = 0;
      end else begin
        m_frame.push_back(d);
        if (m_frame.size() == 4) begin
          for (int i = 0; i < 4; i++) m_out[i] = m_frame[i];
          m_fv = 1;
          m_frame.delete();
        end
      end
    end
  endtask

  task automatic compare_all();
    chk("out0", 32'(out0), 32'(m_out[0]));
    chk("out1", 32'(out1), 32'(m_out[1]));
    chk("out2", 32'(out2), 32'(m_out[2]));
    chk("out3", 32'(out3), 32'(m_out[3]));
    chk("frame_valid", 32'(frame_valid), 32'(m_fv));
    chk("sync_err", 32'(sync_err), 32'(m_err));
    chk("locked", 32'(locked), 32'(m_locked));
    chk("slot", 32'({s1, s0}), 32'(m_frame.size()));
  endtask

  // One clock: apply inputs, let the edge happen, advance model, compare.
  task automatic step(input logic rst, input logic v, input logic [W-1:0] d, input logic fs);
    rst_n      = rst;
    din_valid  = v;
    din        = d;
    frame_sync = fs;
    @(posedge clk);
    model_step(rst, v, d, fs);
    #1;
    compare_all();
  endtask

  task automatic beat(input logic [W-1:0] d, input logic fs);
    step(1'b1, 1'b1, d, fs);
  endtask

  task automatic idle();
    step(1'b1, 1'b0, W'($urandom), 1'($urandom));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    m_locked = 0;
    m_fv     = 0;
    m_err    = 0;
    for (int i = 0; i < 4; i++) m_out[i] = '0;

    // Reset with random inputs
    for (int i = 0; i < 2; i++) step(1'b0, 1'($urandom), W'($urandom), 1'($urandom));

    // Clean frame with single-bit mux pattern
    beat(8'h0, 1'b1); beat(8'h1, 1'b0); beat(8'h0, 1'b0); beat(8'h1, 1'b0);
    idle();

    // Gapped frame
    beat(8'h11, 1'b1); idle(); beat(8'h22, 1'b0); idle(); idle(); beat(8'h33, 1'b0); beat(8'h44, 1'b0);
    idle();

    // Early sync
    beat(8'hA1, 1'b1); beat(8'hA2, 1'b0); beat(8'hB1, 1'b1);
    beat(8'hB2, 1'b0); beat(8'hB3, 1'b0); beat(8'hB4, 1'b0);

    // Missing sync, then relock and a back-to-back frame
    beat(8'h55, 1'b0); beat(8'h56, 1'b0);
    beat(8'hC1, 1'b1); beat(8'hC2, 1'b0); beat(8'hC3, 1'b0); beat(8'hC4, 1'b0);
    beat(8'hD1, 1'b1); beat(8'hD2, 1'b0); beat(8'hD3, 1'b0); beat(8'hD4, 1'b0);

    // Early sync landing on slot 3
    beat(8'hE1, 1'b1); beat(8'hE2, 1'b0); beat(8'hE3, 1'b0); beat(8'hE4, 1'b1);
    idle();

    // Reset mid-frame
    beat(8'h01, 1'b1); beat(8'h02, 1'b0);
    step(1'b0, 1'b1, 8'h03, 1'b0);
    beat(8'h05, 1'b1); beat(8'h06, 1'b0); beat(8'h07, 1'b0); beat(8'h08, 1'b0);
    idle();

    // Randomized traffic, mostly well-formed with injected faults and resets
    for (int i = 0; i < 3000; i++) begin
      logic r, v, fs;
      r  = ($urandom_range(0, 299) != 0);
      v  = ($urandom_range(0, 3) != 0);
      if (m_frame.size() == 0) fs = ($urandom_range(0, 9) != 0);
      else                     fs = ($urandom_range(0, 19) == 0);
      step(r, v, W'($urandom), fs);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
